lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 133 +++++++++++++
 tb/tb_lsu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings
// and the byte-strobe width of the 8-byte data bus.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int STRB_W = 8;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and store data shift, load data shift and extend.
// Purely combinational; all inputs come from the LSU's latched request.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            funct3,
  input  logic [2:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [STRB_W-1:0]     wstrb,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [5:0]            lane_shift;
  logic [DATA_WIDTH-1:0] rshift;

  assign lane_shift = {off, 3'b000};
  assign store_data = wdata << lane_shift;
  assign rshift     = rdata >> lane_shift;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    wstrb = '0;
    unique case (funct3[1:0])
      2'b00:   wstrb = STRB_W'(8'h01) << off;
      2'b01:   wstrb = STRB_W'(8'h03) << off;
      2'b10:   wstrb = STRB_W'(8'h0F) << off;
      default: wstrb = STRB_W'(8'hFF);
    endcase
  end

  always_comb begin
    load_data = rshift;
    unique case (funct3)
      LB:      load_data = {{(DATA_WIDTH-8){rshift[7]}},   rshift[7:0]};
      LH:      load_data = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
      LW:      load_data = {{(DATA_WIDTH-32){rshift[31]}}, rshift[31:0]};
      LBU:     load_data = {{(DATA_WIDTH-8){1'b0}},        rshift[7:0]};
      LHU:     load_data = {{(DATA_WIDTH-16){1'b0}},       rshift[15:0]};
      LWU:     load_data = {{(DATA_WIDTH-32){1'b0}},       rshift[31:0]};
      default: load_data = rshift;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: validates and latches one access, runs the
// request/grant/rvalid handshake on an 8-byte bus and returns the extended load.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] mem_read_o,
  output logic                  done_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [STRB_W-1:0]     wstrb_o,
  input  logic                  gnt_i,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i
);

  state_t                state_q;
  logic [2:0]            funct3_q;
  logic [2:0]            off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  store_q;
  logic                  req_q;
  logic                  done_q;
  logic                  misalign_q;
  logic [DATA_WIDTH-1:0] mem_read_q;

  logic                  one_op;
  logic                  funct3_ok;
  logic                  aligned;
  logic                  accept;
  logic                  illegal;
  logic [STRB_W-1:0]     strb;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] load_data;

  // Request legality, judged on the raw inputs while IDLE.
  assign one_op    = memread_i ^ memwrite_i;
  assign funct3_ok = memwrite_i ? !funct3_i[2] : (funct3_i != 3'b111);
  assign aligned   = (funct3_i[1:0] == 2'b00) ||
                     (funct3_i[1:0] == 2'b01 && addr_i[0]   == 1'b0) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] == 2'b00) ||
                     (funct3_i[1:0] == 2'b11 && addr_i[2:0] == 3'b000);
  assign accept    = (state_q == ST_IDLE) && valid_i && one_op && funct3_ok && aligned;
  assign illegal   = (state_q == ST_IDLE) && valid_i &&
                     ((memread_i && memwrite_i) || (one_op && !(funct3_ok && aligned)));

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_q),
    .off        (off_q),
    .wdata      (wdata_q),
    .rdata      (rdata_i),
    .wstrb      (strb),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      funct3_q   <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      mem_read_q <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            funct3_q <= funct3_i;
            off_q    <= addr_i[2:0];
            addr_q   <= {addr_i[ADDR_WIDTH-1:3], 3'b000};
            wdata_q  <= wdata_i;
            store_q  <= memwrite_i;
            req_q    <= 1'b1;
            state_q  <= ST_REQ;
          end else if (illegal) begin
            misalign_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (gnt_i) begin
            req_q   <= 1'b0;
            done_q  <= store_q;
            state_q <= store_q ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rvalid_i) begin
            mem_read_q <= load_data;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus write-side signals are driven only while a store request is outstanding.
  assign req_o       = req_q;
  assign we_o        = req_q && store_q;
  assign wstrb_o     = (req_q && store_q) ? strb : '0;
  assign bus_wdata_o = (req_q && store_q) ? store_data : '0;
  assign bus_addr_o  = addr_q;
  assign mem_read_o  = mem_read_q;
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;
  assign stall_o     = (state_q == ST_REQ) || (state_q == ST_WAIT) || accept;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads with sign/zero extension, delayed-grant store,
// illegal requests, DONE ignoring valid, and reset aborting a pending load.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, memread_i, memwrite_i, gnt_i, rvalid_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i, wdata_i, rdata_i;
  logic [63:0] mem_read_o, bus_addr_o, bus_wdata_o;
  logic        done_o, stall_o, misalign_o, req_o, we_o;
  logic [7:0]  wstrb_o;

  int checks = 0;
  int errors = 0;

  lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_read_o(mem_read_o), .done_o(done_o), .stall_o(stall_o), .misalign_o(misalign_o),
    .req_o(req_o), .we_o(we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .wstrb_o(wstrb_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; memread_i = 0; memwrite_i = 0; funct3_i = 3'b000;
    addr_i = '0; wdata_i = '0; gnt_i = 0; rvalid_i = 0; rdata_i = '0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    valid_i = 1; memread_i = rd; memwrite_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
  endtask

  task automatic test_reset();
    rst_i = 1; idle_inputs();
    tick(); tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", req_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", we_o); end
    checks++; if (wstrb_o !== 8'h00) begin errors++; $display("FAIL rst_wstrb got %h exp 00", wstrb_o); end
    checks++; if (bus_addr_o !== 64'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_addr_o); end
    checks++; if (bus_wdata_o !== 64'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus_wdata_o); end
    checks++; if (mem_read_o !== 64'h0) begin errors++; $display("FAIL rst_memread got %h exp 0", mem_read_o); end
    checks++; if ({done_o, misalign_o, stall_o} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {done_o, misalign_o, stall_o}); end
    rst_i = 0;
    tick();
  endtask

  task automatic test_lb_sign();
    present(1, 0, LB, 64'h1003, '0); gnt_i = 1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lb_accept_stall got %0b exp 1", stall_o); end
    tick();  // T+1: REQ
    idle_inputs(); gnt_i = 1;
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL lb_req got %0b exp 1", req_o); end
    checks++; if (bus_addr_o !== 64'h1000) begin errors++; $display("FAIL lb_addr got %h exp 1000", bus_addr_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL lb_we got %0b exp 0", we_o); end
    tick();  // T+2: WAIT
    gnt_i = 0; rvalid_i = 1; rdata_i = 64'h0000_0000_8000_0000;
    #1;
    checks++; if ({req_o, done_o, stall_o} !== 3'b001) begin errors++; $display("FAIL lb_wait got %b exp 001", {req_o, done_o, stall_o}); end
    tick();  // T+3: DONE
    rvalid_i = 0; rdata_i = '0;
    #1;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL lb_done_t3 got %0b exp 1", done_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lb_done_stall got %0b exp 0", stall_o); end
    checks++; if (mem_read_o !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffffffffffff80", mem_read_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL lb_done_pulse got %0b exp 0", done_o); end
  endtask

  task automatic test_lwu_zero();
    present(1, 0, LWU, 64'h2004, '0); gnt_i = 1;
    tick();
    idle_inputs(); gnt_i = 1;
    checks++; if (bus_addr_o !== 64'h2000) begin errors++; $display("FAIL lwu_addr got %h exp 2000", bus_addr_o); end
    tick();
    gnt_i = 0; rvalid_i = 1; rdata_i = 64'h8765_4321_0000_0000;
    tick();
    rvalid_i = 0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL lwu_done got %0b exp 1", done_o); end
    checks++; if (mem_read_o !== 64'h0000_0000_8765_4321) begin errors++; $display("FAIL lwu_data got %h exp 0000000087654321", mem_read_o); end
    tick();
  endtask

  task automatic test_sh_delayed_gnt();
    int dones = 0;
    present(0, 1, SH, 64'h3006, 64'hBEEF); gnt_i = 0;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt_i = 1;
      #1;
      dones += int'(done_o);
      checks++; if ({req_o, we_o, stall_o} !== 3'b111) begin errors++; $display("FAIL sh_req_cyc%0d got %b exp 111", i, {req_o, we_o, stall_o}); end
      checks++; if (wstrb_o !== 8'hC0) begin errors++; $display("FAIL sh_wstrb_cyc%0d got %h exp c0", i, wstrb_o); end
      checks++; if (bus_wdata_o !== 64'hBEEF_0000_0000_0000) begin errors++; $display("FAIL sh_wdata_cyc%0d got %h exp beef000000000000", i, bus_wdata_o); end
      checks++; if (bus_addr_o !== 64'h3000) begin errors++; $display("FAIL sh_addr_cyc%0d got %h exp 3000", i, bus_addr_o); end
      tick();
    end
    gnt_i = 0;
    dones += int'(done_o);
    checks++; if ({req_o, done_o, stall_o} !== 3'b010) begin errors++; $display("FAIL sh_done got %b exp 010", {req_o, done_o, stall_o}); end
    checks++; if (mem_read_o !== 64'h0000_0000_8765_4321) begin errors++; $display("FAIL sh_memread_hold got %h exp 0000000087654321", mem_read_o); end
    tick();
    dones += int'(done_o);
    tick();
    dones += int'(done_o);
    checks++; if (dones !== 1) begin errors++; $display("FAIL sh_done_count got %0d exp 1", dones); end
  endtask

  task automatic test_store_sizes();
    logic [2:0]  f3s [2]   = '{SB, SD};
    logic [63:0] adrs[2]   = '{64'h5005, 64'h6000};
    logic [63:0] wds [2]   = '{64'hAA, 64'h0123_4567_89AB_CDEF};
    logic [7:0]  exps[2]   = '{8'h20, 8'hFF};
    logic [63:0] expw[2]   = '{64'h0000_AA00_0000_0000, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 2; i++) begin
      present(0, 1, f3s[i], adrs[i], wds[i]); gnt_i = 1;
      tick();
      idle_inputs(); gnt_i = 1;
      checks++; if (wstrb_o !== exps[i]) begin errors++; $display("FAIL st%0d_wstrb got %h exp %h", i, wstrb_o, exps[i]); end
      checks++; if (bus_wdata_o !== expw[i]) begin errors++; $display("FAIL st%0d_wdata got %h exp %h", i, bus_wdata_o, expw[i]); end
      tick();
      gnt_i = 0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL st%0d_done_t2 got %0b exp 1", i, done_o); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic        rds [4] = '{1, 1, 0, 1};
    logic        wrs [4] = '{0, 1, 1, 0};
    logic [2:0]  f3s [4] = '{LW, LB, 3'b100, 3'b111};
    logic [63:0] adrs[4] = '{64'h4002, 64'h4000, 64'h4000, 64'h4000};
    for (int i = 0; i < 4; i++) begin
      present(rds[i], wrs[i], f3s[i], adrs[i], 64'h1234); gnt_i = 1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL ill%0d_stall got %0b exp 0", i, stall_o); end
      tick();
      idle_inputs(); gnt_i = 1;
      checks++; if ({misalign_o, req_o} !== 2'b10) begin errors++; $display("FAIL ill%0d_pulse got %b exp 10", i, {misalign_o, req_o}); end
      tick();
      checks++; if ({misalign_o, req_o, stall_o} !== 3'b000) begin errors++; $display("FAIL ill%0d_after got %b exp 000", i, {misalign_o, req_o, stall_o}); end
      gnt_i = 0;
    end
  endtask

  task automatic test_nop_and_done_valid();
    present(0, 0, LD, 64'h8000, '0);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nop_stall got %0b exp 0", stall_o); end
    tick();
    checks++; if ({req_o, misalign_o} !== 2'b00) begin errors++; $display("FAIL nop_idle got %b exp 00", {req_o, misalign_o}); end
    present(0, 1, SW, 64'h7000, 64'h5); gnt_i = 1;
    tick();
    idle_inputs(); gnt_i = 1;
    tick();  // DONE; a legal load is offered but must be ignored
    present(1, 0, LD, 64'h9000, '0); gnt_i = 0;
    #1;
    checks++; if ({done_o, stall_o} !== 2'b10) begin errors++; $display("FAIL done_valid got %b exp 10", {done_o, stall_o}); end
    tick();
    idle_inputs();
    checks++; if ({req_o, bus_addr_o} !== {1'b0, 64'h7000}) begin errors++; $display("FAIL done_no_start got req %0b addr %h exp req 0 addr 7000", req_o, bus_addr_o); end
  endtask

  task automatic test_reset_in_wait();
    int dones = 0;
    present(1, 0, LD, 64'hA000, '0); gnt_i = 1;
    tick();
    idle_inputs(); gnt_i = 1;
    tick();  // WAIT
    gnt_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
    checks++; if ({req_o, we_o, done_o, misalign_o, stall_o} !== 5'b0) begin errors++; $display("FAIL rw_flags got %b exp 00000", {req_o, we_o, done_o, misalign_o, stall_o}); end
    checks++; if ({wstrb_o, bus_addr_o, bus_wdata_o, mem_read_o} !== '0) begin errors++; $display("FAIL rw_data got strb %h addr %h wd %h rd %h exp all 0", wstrb_o, bus_addr_o, bus_wdata_o, mem_read_o); end
    rvalid_i = 1; rdata_i = 64'hDEAD;
    tick();
    dones += int'(done_o);
    rvalid_i = 0; rdata_i = '0;
    tick();
    dones += int'(done_o);
    checks++; if (dones !== 0) begin errors++; $display("FAIL rw_done got %0d exp 0", dones); end
    checks++; if (mem_read_o !== 64'h0) begin errors++; $display("FAIL rw_memread got %h exp 0", mem_read_o); end
    checks++; if ({req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL rw_idle got %b exp 00", {req_o, stall_o}); end
  endtask

  initial begin
    test_reset();
    test_lb_sign();
    test_lwu_zero();
    test_sh_delayed_gnt();
    test_store_sizes();
    test_illegal();
    test_nop_and_done_valid();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
